mixn_seq: RTL and testbench
===========================

// Module: mixn_seq
// PURPOSE
//   Parametrised N-voice sample mixer; successor to the fixed 4-input combinational mixer.
//   On each start pulse (one per audio frame) it snapshots NUM_CH signed voice samples.
//   It applies a per-voice unsigned gain and a mute mask, then sums the voices with one
//   multiply-accumulate per clock. The sum is scaled and saturated, then presented to the
//   I2S controller.
// PARAMETERS
//   NUM_CH  4   number of voices (>=1)
//   SAMP_W  16  signed input sample width per voice
//   GAIN_W  8   unsigned gain width per voice; gain g means g/2^GAIN_W
//   OUT_W   16  signed output sample width (<= SAMP_W+GAIN_W)
// PORTS
//   clk         in   1                system clock (slow_clk domain)
//   reset       in   1                synchronous reset, active-low
//   start       in   1                1-cycle frame request; accepted only while idle
//   samp_in     in   NUM_CH*SAMP_W    voice samples, voice i at [i*SAMP_W +: SAMP_W], signed
//   gain        in   NUM_CH*GAIN_W    voice gains, voice i at [i*GAIN_W +: GAIN_W], unsigned
//   mute        in   NUM_CH           1 = voice excluded from the sum
//   busy        out  1                high while state != IDLE
//   samp_out    out  OUT_W            mixed sample, signed, held until the next result
//   samp_valid  out  1                1-cycle strobe when samp_out updates
//   clip        out  1                1 = last result saturated; updates with samp_valid
// BEHAVIOUR
//   - Reset (reset==0 at a clk edge):
//     - state=IDLE; accumulator and index cleared.
//     - samp_out=0, samp_valid=0, clip=0, busy=0.
//     - Reset applied mid-operation aborts the frame with no samp_valid.
//   - States: IDLE -> ACCUM -> SCALE -> IDLE.
//   - IDLE, start=1 at edge E0:
//     - Snapshot samp_in, gain and mute into internal registers.
//     - acc=0, idx=0, go to ACCUM.
//     - Input changes after E0 do not affect this frame.
//   - ACCUM, edges E1..E(NUM_CH):
//     - acc += mute[idx] ? 0 : $signed(samp[idx]) * $signed({1'b0,gain[idx]}).
//     - idx increments. At idx==NUM_CH-1, go to SCALE.
//   - Accumulator width ACC_W = SAMP_W+GAIN_W+1+$clog2(NUM_CH+1). The accumulator never overflows.
//   - SCALE, edge E(NUM_CH+1):
//     - s = acc >>> GAIN_W (arithmetic shift; truncates toward -inf).
//     - s > 2^(OUT_W-1)-1: samp_out = max positive, clip=1.
//     - s < -2^(OUT_W-1): samp_out = min negative, clip=1.
//     - Otherwise samp_out = s[OUT_W-1:0], clip=0.
//     - samp_valid=1 for exactly one cycle; go to IDLE.
//   - Latency: samp_valid is high in the cycle after edge E(NUM_CH+1), NUM_CH+1 clocks after the start edge.
//   - Throughput: one frame per NUM_CH+2 clocks maximum.
//   - start while busy is ignored, not queued. This includes the SCALE cycle.
//     start is next accepted at E(NUM_CH+2).
//   - samp_valid is 0 in every cycle except the strobe cycle. samp_out and clip hold between strobes.
//   - All voices muted: the result is 0, clip=0, and samp_valid still strobes.
//   - Maximum gain (all ones) is just under unity. A full-scale single voice never clips.
// TESTING
//   1. Hold reset=0 for 2 clocks -> samp_out=0, samp_valid=0, clip=0, busy=0.
//   2. Voice0=16'h1000, gain0=128, voices 1-3 muted; pulse start
//      -> samp_out=16'h0800 and clip=0 after exactly 5 clocks; samp_valid high for 1 cycle.
//   3. All voices 16'h7FFF, gain 255 -> samp_out=16'h7FFF, clip=1.
//      All voices 16'h8000, gain 255 -> samp_out=16'h8000, clip=1.
//   4. Voice0=+16'h2000 and voice1=-16'h2000, both gain 255; voice2=16'h7FFF muted; voice3=0
//      -> samp_out=0, clip=0.
//   5. Pulse start at E0 and again at E2 and E5 -> exactly one samp_valid.
//      Changing samp_in at E1 does not alter the result. start at E6 yields a second result.
//   6. Drive reset=0 at E2 of a frame -> no samp_valid, busy=0 next cycle.
//      A fresh start then produces the correct result.

Source files
------------

// File: rtl/mixn_seq_if.sv
// Frame-mixer bus: the frame request and voice data flowing into the mixer,
// and the mixed sample plus status flowing back out to the I2S side.
interface mixn_seq_if #(
  parameter int NUM_CH = 4,
  parameter int SAMP_W = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 16
);
  logic                       start;
  logic [NUM_CH*SAMP_W-1:0]   samp_in;
  logic [NUM_CH*GAIN_W-1:0]   gain;
  logic [NUM_CH-1:0]          mute;
  logic                       busy;
  logic [OUT_W-1:0]           samp_out;
  logic                       samp_valid;
  logic                       clip;

  modport master (
    output start, samp_in, gain, mute,
    input  busy, samp_out, samp_valid, clip
  );

  modport slave (
    input  start, samp_in, gain, mute,
    output busy, samp_out, samp_valid, clip
  );
endinterface

// File: rtl/mixn_seq.sv
// N-voice sequential sample mixer. A start pulse snapshots all voices, one
// multiply-accumulate per clock sums the gained, unmuted voices, and a final
// cycle rescales by the gain fraction and saturates to the output width.
module mixn_seq #(
  parameter int NUM_CH = 4,
  parameter int SAMP_W = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  mixn_seq_if.slave  bus
);

  // Product of a signed sample and a zero-extended gain, and an accumulator
  // wide enough to hold NUM_CH of them without overflow.
  localparam int PROD_W = SAMP_W + GAIN_W + 1;
  localparam int ACC_W  = SAMP_W + GAIN_W + 1 + $clog2(NUM_CH + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic signed [SAMP_W-1:0]  r_samp [NUM_CH];
  logic [GAIN_W-1:0]         r_gain [NUM_CH];
  logic [NUM_CH-1:0]         r_mute;

  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic signed [OUT_W-1:0]   r_samp_out;
  logic                      r_valid;
  logic                      r_clip;

  logic signed [PROD_W-1:0]  w_samp_ext;
  logic signed [PROD_W-1:0]  w_gain_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic                      w_last;
  logic                      w_accept;
  logic [OUT_W:0]            w_sat;

  // Drop the gain fraction bits; arithmetic shift rounds toward -inf.
  function automatic logic signed [ACC_W-1:0] scale_acc(input logic signed [ACC_W-1:0] a);
    return a >>> GAIN_W;
  endfunction

  // Clamp to the signed output range; MSB of the result is the clip flag.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] s);
    if (s > SAT_MAX) begin
      return {1'b1, OUT_MAX};
    end else if (s < SAT_MIN) begin
      return {1'b1, OUT_MIN};
    end else begin
      return {1'b0, s[OUT_W-1:0]};
    end
  endfunction

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_last     = (r_idx == IDX_W'(NUM_CH - 1));
  assign w_samp_ext = PROD_W'(r_samp[r_idx]);
  assign w_gain_ext = PROD_W'({1'b0, r_gain[r_idx]});
  assign w_prod     = w_samp_ext * w_gain_ext;
  assign w_term     = r_mute[r_idx] ? {ACC_W{1'b0}} : ACC_W'(w_prod);
  assign w_sat      = saturate(scale_acc(r_acc));

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.samp_out   = r_samp_out;
  assign bus.samp_valid = r_valid;
  assign bus.clip       = r_clip;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE, so pulses while busy are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ACCUM;
      S_ACCUM: if (w_last)    w_next = S_SCALE;
      S_SCALE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame snapshot so input changes after the accepting edge cannot disturb the sum.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_samp[i] <= bus.samp_in[i*SAMP_W +: SAMP_W];
        r_gain[i] <= bus.gain[i*GAIN_W +: GAIN_W];
      end
      r_mute <= bus.mute;
    end
  end

  // Accumulate one voice per clock, then publish the scaled result with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc      <= '0;
      r_idx      <= '0;
      r_samp_out <= '0;
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 1'b1;
        end
        S_SCALE: begin
          r_samp_out <= w_sat[OUT_W-1:0];
          r_clip     <= w_sat[OUT_W];
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mixn_seq.sv
// Testbench for mixn_seq: directed frames plus randomized frames checked
// against an arithmetic model of the mix (sum, floor-shift, clamp).
module tb_mixn_seq;
  localparam int NUM_CH = 4;
  localparam int SAMP_W = 16;
  localparam int GAIN_W = 8;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mixn_seq_if #(.NUM_CH(NUM_CH), .SAMP_W(SAMP_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus();

  mixn_seq #(.NUM_CH(NUM_CH), .SAMP_W(SAMP_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int                vs [NUM_CH];
  int                gs [NUM_CH];
  logic [NUM_CH-1:0] ms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.samp_in[i*SAMP_W +: SAMP_W] = SAMP_W'(vs[i]);
      bus.gain[i*GAIN_W +: GAIN_W]    = GAIN_W'(gs[i]);
    end
    bus.mute = ms;
  endtask

  // Model: weighted sum of unmuted voices, divided by 2^GAIN_W rounding down, clamped.
  function automatic logic [OUT_W:0] ref_mix();
    longint acc, sh, maxv, minv;
    acc  = 0;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    for (int i = 0; i < NUM_CH; i++)
      if (!ms[i]) acc += longint'(vs[i]) * longint'(gs[i]);
    sh = acc >>> GAIN_W;
    if (sh > maxv) return {1'b1, OUT_W'(maxv)};
    if (sh < minv) return {1'b1, OUT_W'(minv)};
    return {1'b0, OUT_W'(sh)};
  endfunction

  task automatic set_all(input int s, input int g, input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++) begin
      vs[i] = s;
      gs[i] = g;
    end
    ms = m;
  endtask

  // One complete frame: pulse start, wait (bounded) for the strobe, check result and latency.
  task automatic run_frame(input string tag);
    logic [OUT_W:0] e;
    int k;
    bit seen;
    e = ref_mix();
    load();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (bus.samp_valid) seen = 1'b1;
    end
    chk({tag, ".lat"}, 32'(k), 32'(NUM_CH + 1));
    chk({tag, ".out"}, 32'(bus.samp_out), 32'(e[OUT_W-1:0]));
    chk({tag, ".clip"}, 32'(bus.clip), 32'(e[OUT_W]));
    tick();
    chk({tag, ".vld_low"}, 32'(bus.samp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [OUT_W:0] ea, eb;
    logic [OUT_W-1:0] held;
    int k, nv;
    bit seen;

    reset = 1'b0;
    bus.start = 1'b0;
    bus.samp_in = '0;
    bus.gain = '0;
    bus.mute = '0;
    tick();
    tick();
    chk("rst.out", 32'(bus.samp_out), 32'd0);
    chk("rst.vld", 32'(bus.samp_valid), 32'd0);
    chk("rst.clip", 32'(bus.clip), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    tick();

    // Single voice at half gain.
    set_all(0, 0, 4'b1110);
    vs[0] = 'h1000;
    gs[0] = 128;
    run_frame("t2");
    chk("t2.const", 32'(bus.samp_out), 32'h0800);

    // Saturation in both directions.
    set_all(32767, 255, 4'b0000);
    run_frame("t3pos");
    chk("t3pos.const", 32'(bus.samp_out), 32'h7FFF);
    chk("t3pos.clip1", 32'(bus.clip), 32'd1);
    set_all(-32768, 255, 4'b0000);
    run_frame("t3neg");
    chk("t3neg.const", 32'(bus.samp_out), 32'h8000);
    chk("t3neg.clip1", 32'(bus.clip), 32'd1);

    // Cancellation with a muted full-scale voice.
    set_all(0, 255, 4'b0100);
    vs[0] = 'h2000;
    vs[1] = -'h2000;
    vs[2] = 'h7FFF;
    run_frame("t4");
    chk("t4.const", 32'(bus.samp_out), 32'h0000);

    // Full-scale single voice at maximum gain must not clip.
    set_all(0, 255, 4'b1110);
    vs[0] = 32767;
    run_frame("fs_pos");
    chk("fs_pos.const", 32'(bus.samp_out), 32'h7F7F);
    vs[0] = -32768;
    run_frame("fs_neg");
    chk("fs_neg.const", 32'(bus.samp_out), 32'h8080);

    // All voices muted still strobes a zero result.
    set_all(12345, 200, 4'b1111);
    run_frame("allmute");

    // Result holds between strobes.
    held = bus.samp_out;
    set_all(100, 100, 4'b0000);
    vs[0] = 20000;
    run_frame("hold_pre");
    held = bus.samp_out;
    tick();
    tick();
    tick();
    chk("hold.out", 32'(bus.samp_out), 32'(held));
    chk("hold.vld", 32'(bus.samp_valid), 32'd0);

    // Starts while busy are ignored; inputs changed after the accept edge do not leak in.
    vs[0] = 'h1234; vs[1] = -'h0567; vs[2] = 'h7000; vs[3] = 'h0100;
    gs[0] = 200;    gs[1] = 100;     gs[2] = 50;     gs[3] = 255;
    ms = 4'b0000;
    ea = ref_mix();
    load();
    bus.start = 1'b1;
    tick();                                // E0
    bus.start = 1'b0;
    vs[0] = -'h3000; vs[1] = 'h2222; vs[2] = 'h0001; vs[3] = 'h4000;
    gs[0] = 255;     gs[1] = 128;    gs[2] = 10;     gs[3] = 64;
    eb = ref_mix();
    load();
    tick();                                // E1
    bus.start = 1'b1;
    tick();                                // E2
    bus.start = 1'b0;
    chk("t5.e2_vld", 32'(bus.samp_valid), 32'd0);
    tick();                                // E3
    tick();                                // E4
    chk("t5.e4_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    tick();                                // E5
    chk("t5.vld", 32'(bus.samp_valid), 32'd1);
    chk("t5.out_a", 32'(bus.samp_out), 32'(ea[OUT_W-1:0]));
    chk("t5.clip_a", 32'(bus.clip), 32'(ea[OUT_W]));
    tick();                                // E6: second frame accepted
    bus.start = 1'b0;
    chk("t5.e6_vld", 32'(bus.samp_valid), 32'd0);
    chk("t5.e6_busy", 32'(bus.busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (bus.samp_valid) seen = 1'b1;
    end
    chk("t5.lat_b", 32'(k), 32'(NUM_CH + 1));
    chk("t5.out_b", 32'(bus.samp_out), 32'(eb[OUT_W-1:0]));

    // Reset mid-frame aborts with no strobe and clears the outputs.
    set_all(5000, 255, 4'b0000);
    load();
    bus.start = 1'b1;
    tick();                                // E0
    bus.start = 1'b0;
    tick();                                // E1
    reset = 1'b0;
    tick();                                // E2
    chk("t6.busy", 32'(bus.busy), 32'd0);
    chk("t6.vld", 32'(bus.samp_valid), 32'd0);
    chk("t6.out", 32'(bus.samp_out), 32'd0);
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.samp_valid) nv++;
    end
    chk("t6.no_vld", 32'(nv), 32'd0);
    vs[1] = -7000;
    gs[2] = 17;
    ms = 4'b1000;
    run_frame("t6.fresh");

    // Randomized frames; every fourth is pushed toward saturation.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        vs[i] = int'($signed(SAMP_W'($urandom)));
        gs[i] = int'($urandom_range(0, 255));
      end
      ms = NUM_CH'($urandom);
      if (n % 4 == 0) begin
        ms = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          vs[i] = (n % 8 == 0) ? int'($urandom_range(24000, 32767)) : -int'($urandom_range(24000, 32768));
          gs[i] = int'($urandom_range(200, 255));
        end
      end
      run_frame($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
